// File: rtl/apu_dma_arbiter.sv
// rtl/apu_dma_arbiter.sv - sequences OAM sprite DMA and DMC sample fetch onto the 6502 bus
module apu_dma_arbiter #(
  parameter logic [15:0] OAM_REG_ADDR = 16'h2004,
  parameter int          OAM_LEN      = 256
) (
  input  logic        PHI0,
  input  logic        RES,
  input  logic        cpu_rnw,
  input  logic [7:0]  d_in,
  input  logic        oam_start,
  input  logic [7:0]  oam_page,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        RDY,
  output logic        bus_own,
  output logic [15:0] a_out,
  output logic        rnw_out,
  output logic [7:0]  d_out,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
  output logic        oam_busy,
  output logic        dmc_busy,
  output logic        get_cycle
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, HALT, ALIGN, DMC_GET, OAM_GET, OAM_PUT
  } state_t;

  state_t      state, state_next, service;
  logic        oam_pend, dmc_pend;
  logic [7:0]  page;
  logic [15:0] daddr;
  logic [7:0]  count;

  assign oam_busy = oam_pend;
  assign dmc_busy = dmc_pend;

  // DMC always wins the next free get slot over OAM
  always_comb begin
    if (dmc_pend)      service = DMC_GET;
    else if (oam_pend) service = OAM_GET;
    else               service = IDLE;
  end

  always_comb begin
    state_next = state;
    RDY        = 1'b0;
    bus_own    = 1'b0;
    a_out      = 16'h0000;
    rnw_out    = 1'b1;
    unique case (state)
      IDLE: begin
        RDY = 1'b1;
        if (oam_pend || dmc_pend) state_next = HALT;
      end
      HALT: begin
        // a write cycle cannot be halted, so wait for the core to read
        if (cpu_rnw) state_next = get_cycle ? ALIGN : service;
      end
      ALIGN: state_next = service;
      DMC_GET: begin
        bus_own    = 1'b1;
        a_out      = daddr;
        state_next = oam_pend ? ALIGN : IDLE;
      end
      OAM_GET: begin
        bus_own    = 1'b1;
        a_out      = {page, count};
        state_next = OAM_PUT;
      end
      OAM_PUT: begin
        bus_own = 1'b1;
        a_out   = OAM_REG_ADDR;
        rnw_out = 1'b0;
        if (dmc_pend)               state_next = DMC_GET;
        else if (count != LAST_IDX) state_next = OAM_GET;
        else                        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PHI0) begin
    if (RES) begin
      state     <= IDLE;
      get_cycle <= 1'b0;
      oam_pend  <= 1'b0;
      dmc_pend  <= 1'b0;
      page      <= 8'h00;
      daddr     <= 16'h0000;
      count     <= 8'h00;
      d_out     <= 8'h00;
      dmc_data  <= 8'h00;
      dmc_ack   <= 1'b0;
    end else begin
      state     <= state_next;
      get_cycle <= ~get_cycle;
      dmc_ack   <= 1'b0;
      if (oam_start && !oam_pend) begin
        oam_pend <= 1'b1;
        page     <= oam_page;
      end
      if (dmc_req && !dmc_pend) begin
        dmc_pend <= 1'b1;
        daddr    <= dmc_addr;
      end
      unique case (state)
        DMC_GET: begin
          dmc_data <= d_in;
          dmc_ack  <= 1'b1;
          dmc_pend <= 1'b0;
        end
        OAM_GET: d_out <= d_in;
        OAM_PUT: begin
          count <= count + 8'd1;
          if (count == LAST_IDX) oam_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apu_dma_arbiter.sv
// tb/tb_apu_dma_arbiter.sv - directed bench with a bus-slot trace model for apu_dma_arbiter
module tb_apu_dma_arbiter;

  logic        PHI0 = 1'b0;
  logic        RES, cpu_rnw, oam_start, dmc_req;
  logic [7:0]  d_in, oam_page;
  logic [15:0] dmc_addr;
  logic        RDY, bus_own, rnw_out, dmc_ack, oam_busy, dmc_busy, get_cycle;
  logic [15:0] a_out;
  logic [7:0]  d_out, dmc_data;

  always #5 PHI0 = ~PHI0;

  apu_dma_arbiter dut (
    .PHI0(PHI0), .RES(RES), .cpu_rnw(cpu_rnw), .d_in(d_in),
    .oam_start(oam_start), .oam_page(oam_page), .dmc_req(dmc_req), .dmc_addr(dmc_addr),
    .RDY(RDY), .bus_own(bus_own), .a_out(a_out), .rnw_out(rnw_out), .d_out(d_out),
    .dmc_ack(dmc_ack), .dmc_data(dmc_data), .oam_busy(oam_busy), .dmc_busy(dmc_busy),
    .get_cycle(get_cycle)
  );

  typedef struct {
    bit          rdy;
    bit          own;
    logic [15:0] a;
    bit          rnw;
    bit          chk_d;
    logic [7:0]  dval;
    bit          ack;
    logic [7:0]  adata;
    bit          ob;
    bit          db;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc;
  int         nxt;
  int         low_run = 0;
  int         last_low = 0;
  bit         fresh;
  bit         ack_pend;
  logic [7:0] ack_byte;
  logic [7:0] last_ack = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Expected cycles are queued in bus order; an empty queue means the bus is idle.
  function automatic void push(bit rdy, bit own, logic [15:0] a, bit rnw, bit chk_d,
                               logic [7:0] dv, bit ob, bit db);
    exp_t e;
    e.rdy = rdy; e.own = own; e.a = a; e.rnw = rnw; e.chk_d = chk_d; e.dval = dv;
    e.ob = ob; e.db = db; e.ack = ack_pend; e.adata = ack_byte;
    ack_pend = 1'b0;
    q.push_back(e);
    nxt++;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge PHI0);
    cyc++;
    e = '{rdy: 1'b1, own: 1'b0, a: 16'h0000, rnw: 1'b1, chk_d: 1'b0, dval: 8'h00,
          ack: 1'b0, adata: 8'h00, ob: 1'b0, db: 1'b0};
    if (q.size() > 0) e = q.pop_front();
    else if (fresh) begin
      chk("d_out_rst", d_out, 8'h00);
      chk("dmc_data_rst", dmc_data, 8'h00);
    end
    chk("RDY", RDY, e.rdy);
    chk("bus_own", bus_own, e.own);
    chk("a_out", a_out, e.a);
    chk("rnw_out", rnw_out, e.rnw);
    chk("dmc_ack", dmc_ack, e.ack);
    chk("oam_busy", oam_busy, e.ob);
    chk("dmc_busy", dmc_busy, e.db);
    chk("get_cycle", get_cycle, 32'(cyc % 2));
    if (e.chk_d) chk("d_out", d_out, e.dval);
    if (e.ack) chk("dmc_data", dmc_data, e.adata);
    if (dmc_ack === 1'b1) last_ack = dmc_data;
    if (RDY === 1'b0) low_run++;
    else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end
    d_in = a_out[7:0];
  endtask

  task automatic run_xfer(input bit do_oam, input bit dmc_first, input logic [7:0] page,
                          input logic [15:0] daddr, input int stall, input bit halt_get,
                          input int mid, input int exp_low, input int abort_at);
    int c0, req_cyc, n;
    bit db, aborted;
    tick();
    while (((cyc + 2 + stall) % 2) != int'(halt_get)) tick();
    c0 = cyc;
    fresh = 1'b0;
    oam_start = do_oam; oam_page = page;
    dmc_req = dmc_first; dmc_addr = daddr;
    cpu_rnw = 1'b1;

    nxt = c0 + 1;
    req_cyc = -1;
    push(1, 0, 16'h0, 1, 0, 8'h0, do_oam, dmc_first);
    for (int i = 0; i <= stall; i++) push(0, 0, 16'h0, 1, 0, 8'h0, do_oam, dmc_first);
    if (((c0 + 2 + stall) % 2) == 1) push(0, 0, 16'h0, 1, 0, 8'h0, do_oam, dmc_first);
    if (dmc_first) begin
      push(0, 1, daddr, 1, 0, 8'h0, do_oam, 1);
      ack_pend = 1'b1; ack_byte = daddr[7:0];
      if (do_oam) push(0, 0, 16'h0, 1, 0, 8'h0, 1, 0);
    end
    if (do_oam) begin
      for (int i = 0; i < 256; i++) begin
        db = (mid >= 0 && i == mid + 1);
        push(0, 1, {page, 8'(i)}, 1, 0, 8'h0, 1, db);
        if (mid >= 0 && i == mid) req_cyc = nxt;
        push(0, 1, 16'h2004, 0, 1, 8'(i), 1, db);
        if (db) begin
          push(0, 1, daddr, 1, 0, 8'h0, 1, 1);
          ack_pend = 1'b1; ack_byte = daddr[7:0];
          push(0, 0, 16'h0, 1, 0, 8'h0, 1, 0);
        end
      end
    end
    if (ack_pend) push(1, 0, 16'h0, 1, 0, 8'h0, 0, 0);

    n = 0;
    aborted = 1'b0;
    while (q.size() > 0 && n < 2000) begin
      tick();
      n++;
      oam_start = 1'b0;
      dmc_req = (cyc == req_cyc);
      cpu_rnw = !(cyc >= c0 + 2 && cyc < c0 + 2 + stall);
      if (abort_at >= 0 && n == abort_at) begin
        RES = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    dmc_req = 1'b0;
    cpu_rnw = 1'b1;
    if (aborted) begin
      q.delete();
      ack_pend = 1'b0;
      cyc = -1;
      fresh = 1'b1;
      low_run = 0;
      tick();
      RES = 1'b0;
    end else begin
      chk("drain", q.size(), 0);
      repeat (2) tick();
      if (exp_low > 0) chk("rdy_low_len", last_low, exp_low);
    end
  endtask

  initial begin
    RES = 1'b1; cpu_rnw = 1'b1; oam_start = 1'b0; dmc_req = 1'b0;
    d_in = 8'h00; oam_page = 8'h00; dmc_addr = 16'h0000;
    ack_pend = 1'b0; ack_byte = 8'h00; nxt = 0;
    @(negedge PHI0);
    cyc = -1;
    fresh = 1'b1;
    tick();
    RES = 1'b0;
    repeat (10) tick();

    run_xfer(1, 0, 8'h02, 16'h0000, 0, 0, -1, 513, -1);
    run_xfer(1, 0, 8'h02, 16'h0000, 0, 1, -1, 514, -1);
    run_xfer(1, 0, 8'h02, 16'h0000, 3, 0, -1, 516, -1);
    run_xfer(1, 0, 8'h02, 16'hC123, 0, 0, 99, 515, -1);
    chk("dmc_byte_c123", last_ack, 8'h23);
    run_xfer(0, 1, 8'h00, 16'hC1A5, 0, 0, -1, 2, -1);
    chk("dmc_byte_c1a5", last_ack, 8'hA5);
    run_xfer(0, 1, 8'h00, 16'h8042, 0, 1, -1, 3, -1);
    run_xfer(1, 1, 8'h03, 16'h8001, 0, 0, -1, 515, -1);
    chk("dmc_byte_8001", last_ack, 8'h01);
    run_xfer(1, 0, 8'h02, 16'h0000, 0, 0, -1, -1, 300);
    repeat (4) tick();
    run_xfer(1, 0, 8'h04, 16'h0000, 0, 1, -1, 514, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_dma_arbiter.md
Name: apu_dma_arbiter

Overview:
Sequences the APU's two DMA engines, sprite OAM DMA and DMC sample fetch, onto the embedded 6502 bus. It halts the core through RDY, aligns to the get/put cycle phase, and drives address, data and R/W while it owns the bus. It sits between the register decoder ($4014 write and DMC request) and the core/pad bus mux, and steps once per CPU cycle.

Parameters:
OAM_REG_ADDR, 16'h2004, destination address for every OAM put write
OAM_LEN, 256, bytes per OAM transfer (counter width 8)

Ports:
PHI0  input  1  CPU-cycle clock; all state advances on rising edge
RES  input  1  reset, synchronous, active-high
cpu_rnw  input  1  core R/W for the current cycle (1 = read)
d_in  input  8  data bus sampled at end of cycle
oam_start  input  1  1-cycle pulse, $4014 written
oam_page  input  8  source page, latched with oam_start
dmc_req  input  1  1-cycle pulse, DMC needs a sample byte
dmc_addr  input  16  DMC fetch address, latched with dmc_req
RDY  output  1  to core; 0 halts the core on read cycles
bus_own  output  1  1 = arbiter drives a_out/rnw_out/d_out onto the bus
a_out  output  16  DMA address
rnw_out  output  1  DMA R/W
d_out  output  8  OAM write data
dmc_ack  output  1  1-cycle pulse, dmc_data valid
dmc_data  output  8  fetched DMC byte
oam_busy  output  1  OAM transfer pending or active
dmc_busy  output  1  DMC fetch pending
get_cycle  output  1  phase flag; 1 = get (read) slot

Behaviour:
- One clock, PHI0. Reset is synchronous and active-high (RES).
- Reset values: state=IDLE, get_cycle=0, RDY=1, bus_own=0, rnw_out=1, a_out=0, d_out=0, dmc_ack=0, dmc_data=0, oam_busy=0, dmc_busy=0, counter=0, all pending flags cleared. RES mid-transfer aborts immediately and RDY=1 on the next cycle.
- get_cycle toggles every cycle after reset; first post-reset cycle has get_cycle=0.
- Requests:
  - oam_start sets oam pending and latches oam_page. It is ignored while oam_busy=1.
  - dmc_req sets dmc pending and latches dmc_addr. It is ignored (dropped) while dmc_busy=1.
  - Simultaneous requests: both latched; DMC is served first.
- States: IDLE, HALT, ALIGN, DMC_GET, OAM_GET, OAM_PUT. RDY=1 only in IDLE. bus_own=1 only in DMC_GET, OAM_GET and OAM_PUT.
- IDLE: any pending request moves to HALT next cycle.
- HALT (RDY=0):
  - If cpu_rnw=0, stay in HALT, because the core cannot halt on a write.
  - If cpu_rnw=1, this is the halt cycle. Go to the service state if the next cycle is a get slot; otherwise go to ALIGN.
- ALIGN: one dummy cycle, bus_own=0, then the service state. Service state is DMC_GET if dmc pending, else OAM_GET.
- DMC_GET:
  - a_out=dmc_addr, rnw_out=1.
  - d_in is captured into dmc_data; dmc_ack=1 on the following cycle; dmc pending cleared.
  - Next state: ALIGN if oam pending/active, else IDLE.
- OAM_GET: a_out={page,counter}, rnw_out=1, d_in latched into d_out. Next state OAM_PUT.
- OAM_PUT:
  - a_out=OAM_REG_ADDR, rnw_out=0, d_out held; counter increments, wrapping 255 to 0.
  - Next state: DMC_GET if dmc pending. Otherwise OAM_GET if counter was not 255. Otherwise IDLE, with oam pending cleared.
- DMC interrupting OAM: the DMC get takes the next get slot after a completed put; one ALIGN follows; OAM resumes at the next get with the counter unchanged.
- Timing:
  - OAM alone: RDY low for 513 cycles (halt on put) or 514 (halt on get, plus ALIGN).
  - DMC alone: RDY low for 2 or 3 cycles.
  - RDY returns high the cycle after the last bus cycle.

Test Plan:
- RES for 2 cycles, then idle for 10 -> RDY=1, bus_own=0, get_cycle alternates 0,1,0,…; all outputs at reset values.
- oam_start with page 8'h02 on a cycle whose HALT lands on a put, cpu_rnw=1, memory returns data = low address byte -> RDY low for exactly 513 cycles; gets read 16'h0200..16'h02FF; puts write 16'h2004 with data 0x00..0xFF; oam_busy falls with RDY.
- Same stimulus but HALT lands on a get -> one ALIGN cycle with bus_own=0; RDY low for 514 cycles.
- oam_start while cpu_rnw=0 for 3 cycles -> arbiter stays in HALT for those 3 cycles; the first transfer starts only after cpu_rnw=1.
- dmc_req with address 16'hC123 at the 100th OAM put -> DMC_GET at 16'hC123 in the next get slot; dmc_ack pulses once with the read byte; one ALIGN; OAM resumes at the next source byte; total RDY-low time grows by 2.
- dmc_req and oam_start in the same cycle -> DMC get first, then ALIGN, then OAM; RES asserted mid-OAM -> next cycle RDY=1, bus_own=0, oam_busy=0, counter=0.
